// File: rtl/ddr_app_arbiter.sv
// Two-requester arbiter for the DDR3 MIG app_* interface with tagged read-return steering.
// Define DDR_ARB_FIXED_PRIO_EN to give requester 0 fixed priority instead of round-robin.
module ddr_app_arbiter #(
  parameter int TAG_DEPTH = 8,
  parameter int ADDR_W    = 27
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           init_calib_complete,
  input  logic [ADDR_W-1:0]              rq0_addr,
  input  logic [2:0]                     rq0_cmd,
  input  logic                           rq0_en,
  output logic                           rq0_rdy,
  input  logic [63:0]                    rq0_wdf_data,
  input  logic                           rq0_wdf_wren,
  input  logic                           rq0_wdf_end,
  output logic                           rq0_wdf_rdy,
  output logic [63:0]                    rq0_rd_data,
  output logic                           rq0_rd_valid,
  output logic                           rq0_rd_end,
  input  logic [ADDR_W-1:0]              rq1_addr,
  input  logic [2:0]                     rq1_cmd,
  input  logic                           rq1_en,
  output logic                           rq1_rdy,
  input  logic [63:0]                    rq1_wdf_data,
  input  logic                           rq1_wdf_wren,
  input  logic                           rq1_wdf_end,
  output logic                           rq1_wdf_rdy,
  output logic [63:0]                    rq1_rd_data,
  output logic                           rq1_rd_valid,
  output logic                           rq1_rd_end,
  output logic [ADDR_W-1:0]              app_addr,
  output logic [2:0]                     app_cmd,
  output logic                           app_en,
  input  logic                           app_rdy,
  output logic [63:0]                    app_wdf_data,
  output logic                           app_wdf_wren,
  output logic                           app_wdf_end,
  input  logic                           app_wdf_rdy,
  input  logic [63:0]                    app_rd_data,
  input  logic                           app_rd_data_valid,
  input  logic                           app_rd_data_end,
  output logic [$clog2(TAG_DEPTH+1)-1:0] rd_outstanding,
  output logic                           arb_err,
  output logic [1:0]                     fsm_state
);

  localparam int CW = $clog2(TAG_DEPTH + 1);
  localparam int PW = $clog2(TAG_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, WDATA0 = 2'd2, WDATA1 = 2'd3} state_t;

  state_t               state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 last_grant_q, last_grant_d;
  logic                 err_q, err_d;
  logic [TAG_DEPTH-1:0] tag_q, tag_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;

  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_cmd;
  logic              sel_en, sel_wren, sel_end;
  logic [63:0]       sel_wdata;
  logic              tag_full, tag_empty, tag_head;
  logic              cmd_acc, beat, push, pop;

  assign sel_addr  = grant_q ? rq1_addr     : rq0_addr;
  assign sel_cmd   = grant_q ? rq1_cmd      : rq0_cmd;
  assign sel_en    = grant_q ? rq1_en       : rq0_en;
  assign sel_wdata = grant_q ? rq1_wdf_data : rq0_wdf_data;
  assign sel_wren  = grant_q ? rq1_wdf_wren : rq0_wdf_wren;
  assign sel_end   = grant_q ? rq1_wdf_end  : rq0_wdf_end;

  assign tag_full  = (count_q == CW'(TAG_DEPTH));
  assign tag_empty = (count_q == '0);
  assign tag_head  = tag_q[rd_ptr_q];

  assign rq0_rd_data    = app_rd_data;
  assign rq1_rd_data    = app_rd_data;
  assign rd_outstanding = count_q;
  assign arb_err        = err_q;
  assign fsm_state      = state_q;

  // Command/write-data FSM
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    app_addr     = '0;
    app_cmd      = 3'b001;
    app_en       = 1'b0;
    app_wdf_data = '0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    rq0_rdy      = 1'b0;
    rq1_rdy      = 1'b0;
    rq0_wdf_rdy  = 1'b0;
    rq1_wdf_rdy  = 1'b0;
    cmd_acc      = 1'b0;
    beat         = 1'b0;
    push         = 1'b0;
    case (state_q)
      IDLE: begin
        if (init_calib_complete && (rq0_en || rq1_en)) begin
`ifdef DDR_ARB_FIXED_PRIO_EN
          grant_d = !rq0_en;
`else
          if (rq0_en && rq1_en) grant_d = !last_grant_q;
          else                  grant_d = rq1_en;
`endif
          last_grant_d = grant_d;
          state_d      = CMD;
        end
      end
      CMD: begin
        app_addr = sel_addr;
        app_cmd  = sel_cmd;
        // Reads stall while every tag slot is in use.
        app_en   = sel_en && !((sel_cmd == 3'b001) && tag_full);
        cmd_acc  = app_en && app_rdy;
        rq0_rdy  = cmd_acc && !grant_q;
        rq1_rdy  = cmd_acc && grant_q;
        if (!sel_en) begin
          state_d = IDLE;
        end else if (cmd_acc) begin
          case (sel_cmd)
            3'b000:  state_d = WDATA0;
            3'b001: begin
              push    = 1'b1;
              state_d = IDLE;
            end
            default: begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          endcase
        end
      end
      WDATA0, WDATA1: begin
        app_wdf_data = sel_wdata;
        app_wdf_wren = sel_wren;
        app_wdf_end  = sel_end;
        rq0_wdf_rdy  = app_wdf_rdy && !grant_q;
        rq1_wdf_rdy  = app_wdf_rdy && grant_q;
        beat         = sel_wren && app_wdf_rdy;
        if (beat) begin
          if (sel_end != (state_q == WDATA1)) err_d = 1'b1;
          state_d = (state_q == WDATA0) ? WDATA1 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (app_rd_data_valid && tag_empty) err_d = 1'b1;
  end

  // Read-return steering and tag FIFO bookkeeping, independent of the FSM
  always_comb begin
    rq0_rd_valid = app_rd_data_valid && !tag_empty && !tag_head;
    rq1_rd_valid = app_rd_data_valid && !tag_empty && tag_head;
    rq0_rd_end   = rq0_rd_valid && app_rd_data_end;
    rq1_rd_end   = rq1_rd_valid && app_rd_data_end;
    pop          = app_rd_data_valid && app_rd_data_end && !tag_empty;
    tag_d        = tag_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    if (push) begin
      tag_d[wr_ptr_q] = grant_q;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      tag_q        <= tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: doc/ddr_app_arbiter.md
Name: ddr_app_arbiter

Overview:
- Two-requester arbiter for the DDR3 MIG user (app_*) interface, 64-bit data, 2:1 clock mode.
- Shares the MIG command and write-data FIFOs between two requesters:
  - requester 0: SD-card loader, writes only.
  - requester 1: pixel/sprite fetch engine, reads and writes.
- Tracks outstanding reads in a tag FIFO and steers returned read bursts to the requester that issued them.
- Sits between the requesters and the MIG; no address translation.

Parameters:
TAG_DEPTH, 8, number of outstanding reads tracked (power of 2, ≥2)
ADDR_W, 27, app address width

Ports:
clk  input  1  MIG ui_clk
reset  input  1  asynchronous, active-high
init_calib_complete  input  1  MIG calibration done; no grants while low
rqN_addr  input  ADDR_W  requester N (N=0,1) command address
rqN_cmd  input  3  000=write, 001=read
rqN_en  input  1  command request, held until rqN_rdy
rqN_rdy  output  1  command accepted this cycle
rqN_wdf_data  input  64  write beat
rqN_wdf_wren  input  1  write beat valid
rqN_wdf_end  input  1  last beat of burst
rqN_wdf_rdy  output  1  write beat accepted this cycle
rqN_rd_data  output  64  read beat (shared fan-out of app_rd_data)
rqN_rd_valid  output  1  read beat valid for requester N
rqN_rd_end  output  1  last beat of read burst for N
app_addr  output  ADDR_W  to MIG
app_cmd  output  3  to MIG
app_en  output  1  to MIG
app_rdy  input  1  from MIG
app_wdf_data  output  64  to MIG
app_wdf_wren  output  1  to MIG
app_wdf_end  output  1  to MIG
app_wdf_rdy  input  1  from MIG
app_rd_data  input  64  from MIG
app_rd_data_valid  input  1  from MIG
app_rd_data_end  input  1  from MIG
rd_outstanding  output  $clog2(TAG_DEPTH+1)  reads issued, not yet completed
arb_err  output  1  sticky protocol-error flag

Behaviour:

Reset:
- Asynchronous, active-high.
- All outputs 0, app_cmd=001.
- FSM=IDLE; tag FIFO empty; rd_outstanding=0; arb_err=0.
- last_grant=1, so requester 0 wins the first tie.

FSM states: IDLE, CMD, WDATA0, WDATA1.

IDLE:
- Requires init_calib_complete=1 and at least one rqN_en=1.
- Round-robin choice: the requester other than last_grant wins a tie.
- Registers grant G, updates last_grant, goes to CMD.
- Grant latency is 1 cycle; no command is issued from IDLE.

CMD:
- app_addr and app_cmd pass through combinationally from requester G.
- app_en = rqG_en AND NOT (rqG_cmd==001 AND tag FIFO full).
- rqG_rdy = app_en AND app_rdy. rq(!G)_rdy = 0.
- On accept with cmd=000: go to WDATA0.
- On accept with cmd=001: push G into the tag FIFO, go to IDLE.
- On accept with any other cmd: forward it, no push, set arb_err, go to IDLE.
- If rqG_en drops before accept: go to IDLE.

WDATA0 / WDATA1:
- app_wdf_* pass through from requester G.
- rqG_wdf_rdy = app_wdf_rdy. rq(!G)_wdf_rdy = 0.
- WDATA0 → WDATA1 on wren AND app_wdf_rdy.
- WDATA1 → IDLE on wren AND app_wdf_rdy.
- If wdf_end is not 0 then 1 on the two beats, set arb_err; the beat is still forwarded.

Read return:
- Head of tag FIFO H routes the beat: rqH_rd_valid = app_rd_data_valid, rqH_rd_end = app_rd_data_end.
- Pop the FIFO on app_rd_data_valid AND app_rd_data_end.
- app_rd_data_valid with the FIFO empty: no rd_valid asserted, set arb_err.
- The return path is independent of the FSM.
- A push and a pop in the same cycle are both performed; rd_outstanding is unchanged.

Other rules:
- rd_outstanding = FIFO occupancy, registered.
- arb_err clears only on reset.
- Reset mid-burst abandons the burst; requesters are also reset.

Optional Feature:
DDR_ARB_FIXED_PRIO_EN
- Defined: requester 0 always wins simultaneous requests, so the SD loader preempts fetch between bursts. last_grant is ignored. A burst in progress is never preempted.
- Undefined: round-robin as specified above.

Test Plan:
- Reset with init_calib_complete=0 and both rqN_en=1 → app_en=0 and no rdy for 20 cycles. Raise calib → rq0 granted first; app_en high 1 cycle after IDLE.
- rq0 write, addr 0x000010, beats 0xA/0xB, app_wdf_rdy stalled 3 cycles → two beats appear on app_wdf_data in order, wdf_end on beat 2, FSM returns to IDLE.
- Both requesting continuously (round-robin build) → grants alternate 0,1,0,1 over 8 commands. With DDR_ARB_FIXED_PRIO_EN defined → all 8 go to rq0.
- Interleaved reads rq1@0x100, rq0@0x200, rq1@0x300; MIG returns 3 bursts in order → rd_valid on rq1, rq0, rq1 respectively; rd_outstanding goes 3→0.
- Issue 8 reads with the MIG withholding data → 9th read keeps app_en=0 and rq_rdy=0. First return burst end → 9th read accepted the next cycle.
- app_rd_data_valid pulse with nothing outstanding → no rqN_rd_valid, arb_err=1 and stays set until reset.
